// File: rtl/spi_controller_regif.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller_regif
// Brief    : SPI initiator issuing single-register read/write frames
//            (command byte + REG_W-bit data field, MSB first) to an SPI
//            register peripheral. Supports all four SPI modes.
// Optional : SPI_CTRL_CS_GAP_EN adds a 2*CLK_DIV-cycle CS-high gap after
//            each frame during which busy stays high.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller_regif #(
    parameter int ADDR_W  = 4,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              wr_rdn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [REG_W-1:0]  rdata,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int F     = 8 + REG_W;
    localparam int BIT_W = $clog2(2 * F + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] LAST_EDGE  = BIT_W'(2 * F - 1);
    localparam logic [BIT_W-1:0] DATA_EDGE0 = BIT_W'(16);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic               wr_q;
    logic [F-1:0]       sh;
    logic [REG_W-1:0]   rx;
    logic [DIV_W-1:0]   div;
    logic [BIT_W-1:0]   bcnt;
    logic [7:0]         cmd_w;
    logic [F-1:0]       frame_w;
`ifdef SPI_CTRL_CS_GAP_EN
    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * CLK_DIV - 1);
    logic [GAP_W-1:0]   gap;
`endif

    // Assemble the outgoing frame: zero-extended address with R/W flag in bit 7
    always_comb begin
        cmd_w    = 8'(addr);
        cmd_w[7] = wr_rdn;
        frame_w  = {cmd_w, (wr_rdn ? wdata : {REG_W{1'b0}})};
    end

    // Frame sequencer: divider, edge counter, shift/sample and pin drivers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= S_IDLE;
            mode_q   <= 2'b00;
            wr_q     <= 1'b0;
            sh       <= '0;
            rx       <= '0;
            div      <= '0;
            bcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
`ifdef SPI_CTRL_CS_GAP_EN
            gap      <= '0;
`endif
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    spi_cs_n <= 1'b1;
                    spi_clk  <= mode[1];
                    if (start) begin
                        mode_q   <= mode;
                        wr_q     <= wr_rdn;
                        sh       <= frame_w;
                        spi_mosi <= frame_w[F-1];
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div      <= '0;
                        bcnt     <= '0;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div == DIV_LAST) begin
                        div  <= '0;
                        bcnt <= bcnt + BIT_W'(1);
                        // Last edge parks SCLK at the latched idle polarity
                        spi_clk <= (bcnt == LAST_EDGE) ? mode_q[1] : ~spi_clk;
                        if (bcnt[0] == 1'b0) begin
                            // Odd (leading) edge
                            if (!mode_q[0]) begin
                                if (bcnt >= DATA_EDGE0)
                                    rx <= REG_W'({rx, spi_miso});
                            end else begin
                                spi_mosi <= sh[F-1];
                                sh       <= sh << 1;
                            end
                        end else begin
                            // Even (trailing) edge
                            if (!mode_q[0]) begin
                                if (bcnt != LAST_EDGE) begin
                                    spi_mosi <= sh[F-2];
                                    sh       <= sh << 1;
                                end
                            end else if (bcnt >= DATA_EDGE0) begin
                                rx <= REG_W'({rx, spi_miso});
                            end
                        end
                        if (bcnt == LAST_EDGE)
                            state <= S_HOLD;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        if (!wr_q)
                            rdata <= rx;
`ifdef SPI_CTRL_CS_GAP_EN
                        gap   <= '0;
                        state <= S_GAP;
`else
                        busy  <= 1'b0;
                        state <= S_IDLE;
`endif
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                default: begin
`ifdef SPI_CTRL_CS_GAP_EN
                    // Enforced CS-high recovery time; start is ignored here
                    if (gap == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
`else
                    state <= S_IDLE;
`endif
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller_regif
// Brief    : Self-checking bench for spi_controller_regif with a behavioural
//            SPI responder/monitor and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller_regif;

    localparam int ADDR_W  = 4;
    localparam int REG_W   = 8;
    localparam int CLK_DIV = 2;
    localparam int F       = 8 + REG_W;
    localparam int FRAME_T = (2 * F + 1) * CLK_DIV;
`ifdef SPI_CTRL_CS_GAP_EN
    localparam logic BUSY_AT_DONE = 1'b1;
`else
    localparam logic BUSY_AT_DONE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              ena = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              start = 1'b0;
    logic              wr_rdn = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [REG_W-1:0]  wdata = '0;
    logic              busy, done, spi_cs_n, spi_clk, spi_mosi;
    logic              spi_miso = 1'b0;
    logic [REG_W-1:0]  rdata;

    spi_controller_regif #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .start(start),
        .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expectations for the frame currently on the wire
    logic [15:0]      exp_frame;
    logic             exp_cpol, exp_cpha;
    logic [REG_W-1:0] exp_resp;
    logic [REG_W-1:0] exp_rdata = '0;
    int               exp_freeze = 0;

    // Monitor state
    logic ena_q = 1'b1;
    logic prev_cs = 1'b1, prev_clk = 1'b0;
    logic [15:0] cap;
    int t, r, e, nrise, hi_len = 0, last_hi = 0, done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic resp_bit(input int b);
        if (b >= 8 && b < F) return exp_resp[F - 1 - b];
        return 1'b0;
    endfunction

    always @(posedge clk) ena_q = ena;

    // Responder and protocol monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (!rstb) begin
            prev_cs  = 1'b1;
            prev_clk = 1'b0;
            hi_len   = 0;
        end else begin
            if (!prev_cs) begin
                r++;
                if (ena_q) t++;
            end
            if (prev_cs && !spi_cs_n) begin
                last_hi = hi_len;
                r = 0; t = 0; e = 0; nrise = 0; cap = '0;
                check("sclk_idle", spi_clk, exp_cpol);
                check("first_mosi", spi_mosi, exp_frame[15]);
                spi_miso = resp_bit(0);
            end else if (!spi_cs_n && spi_clk != prev_clk) begin
                e++;
                check("edge_time", t, e * CLK_DIV);
                if (spi_clk) nrise++;
                if (((e % 2) == 1) != exp_cpha) begin
                    check("sample_pol", spi_clk, exp_cpol == exp_cpha);
                    cap = {cap[14:0], spi_mosi};
                end
                spi_miso = resp_bit(exp_cpha ? e / 2 : (e + 1) / 2);
            end
            if (!prev_cs && spi_cs_n) hi_len = 0;
            if (spi_cs_n) hi_len++;
            if (done) begin
                done_cnt++;
                check("done_time", t, FRAME_T);
                check("done_raw_time", r, FRAME_T + exp_freeze);
                check("edge_count", e, 2 * F);
                check("rise_count", nrise, F);
                check("mosi_frame", cap, exp_frame);
                check("cs_at_done", spi_cs_n, 1'b1);
                check("busy_at_done", busy, BUSY_AT_DONE);
            end
            prev_cs  = spi_cs_n;
            prev_clk = spi_clk;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Load DUT inputs and reference expectations for one frame
    task automatic setup(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [REG_W-1:0] wd, input logic [1:0] md,
                         input logic [REG_W-1:0] resp);
        wr_rdn = wr; addr = a; wdata = wd; mode = md;
        exp_frame = 16'((int'(wr) << 15) | (int'(a) << 8) | (wr ? int'(wd) : 0));
        exp_cpol = md[1]; exp_cpha = md[0];
        exp_resp = resp;
        exp_freeze = 0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 400) begin tick(); n++; end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
        if (!wr_rdn) exp_rdata = exp_resp;
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    task automatic run_frame(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [REG_W-1:0] wd, input logic [1:0] md,
                             input logic [REG_W-1:0] resp);
        setup(wr, a, wd, md, resp);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(tag);
        repeat (2 * CLK_DIV + 2) tick();
    endtask

    task automatic wait_edges(input int k);
        int n = 0;
        while (e < k && n < 400) begin tick(); n++; end
        if (e < k) check("edge_wait_timeout", 0, 1);
    endtask

    logic [3:0] snap;
    int d_save;

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_cs", spi_cs_n, 1'b1);
        check("rst_sclk", spi_clk, 1'b0);
        rstb = 1'b1;
        tick();
        check("post_rst_outs", {busy, done, spi_cs_n, spi_clk, spi_mosi}, 5'b00100);
        check("post_rst_rdata", rdata, 8'h00);

        // Directed frames: write, read, write-leaves-rdata, other modes
        run_frame("wr_a5", 1'b1, 4'h3, 8'hA5, 2'd0, 8'h00);
        run_frame("rd_3c", 1'b0, 4'h9, 8'hFF, 2'd0, 8'h3C);
        run_frame("wr_keep", 1'b1, 4'h1, 8'h77, 2'd0, 8'hC3);
        run_frame("rd_m3", 1'b0, 4'h5, 8'h00, 2'd3, 8'h5A);
        run_frame("rd_m1", 1'b0, 4'h6, 8'h00, 2'd1, 8'h5A);
        run_frame("rd_m2", 1'b0, 4'h7, 8'h00, 2'd2, 8'h5A);

        // Randomized frames against the reference model
        for (int i = 0; i < 10; i++)
            run_frame("rand", 1'($urandom), 4'($urandom), 8'($urandom),
                      2'($urandom), 8'($urandom));

        // Start pulsed during busy with a mode change: ignored
        d_save = done_cnt;
        setup(1'b0, 4'hC, 8'h00, 2'd1, 8'h96);
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        mode = 2'd2; wr_rdn = 1'b1; start = 1'b1; tick(); start = 1'b0;
        wr_rdn = 1'b0;
        wait_done("busy_start");
        repeat (FRAME_T + 10) tick();
        check("single_done", done_cnt, d_save + 1);

        // Start held while ena=0: ignored
        ena = 1'b0; start = 1'b1;
        repeat (5) tick();
        check("ena0_busy", busy, 1'b0);
        check("ena0_cs", spi_cs_n, 1'b1);
        start = 1'b0; ena = 1'b1;
        repeat (3) tick();
        check("ena0_after_busy", busy, 1'b0);

        // ena low for 10 cycles after edge 5: pins frozen, done delayed 10
        setup(1'b1, 4'hB, 8'h3E, 2'd0, 8'h00);
        start = 1'b1; tick(); start = 1'b0;
        wait_edges(5);
        ena = 1'b0;
        exp_freeze = 10;
        snap = {spi_cs_n, spi_clk, spi_mosi, busy};
        for (int i = 0; i < 10; i++) begin
            tick();
            check("frozen_pins", {spi_cs_n, spi_clk, spi_mosi, busy}, snap);
        end
        ena = 1'b1;
        wait_done("freeze");
        repeat (2 * CLK_DIV + 2) tick();

        // Asynchronous reset mid-frame at edge 7: no done pulse
        d_save = done_cnt;
        setup(1'b0, 4'h2, 8'h00, 2'd3, 8'hE1);
        start = 1'b1; tick(); start = 1'b0;
        wait_edges(7);
        rstb = 1'b0;
        #1;
        check("arst_cs", spi_cs_n, 1'b1);
        check("arst_sclk", spi_clk, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_rdata", rdata, 8'h00);
        exp_rdata = '0;
        repeat (2) tick();
        rstb = 1'b1;
        mode = 2'd0;
        repeat (FRAME_T + 10) tick();
        check("arst_no_done", done_cnt, d_save);

        // Back-to-back frames: CS-high spacing
        setup(1'b1, 4'h4, 8'h81, 2'd0, 8'h00);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("b2b_a");
        setup(1'b0, 4'hD, 8'h00, 2'd0, 8'h6B);
        start = 1'b1;
        begin
            int n = 0;
            while (spi_cs_n && n < 50) begin tick(); n++; end
        end
        start = 1'b0;
        check("b2b_cs_fell", spi_cs_n, 1'b0);
`ifdef SPI_CTRL_CS_GAP_EN
        check("b2b_gap", last_hi >= 2 * CLK_DIV + 1, 1'b1);
`else
        check("b2b_gap", last_hi <= 2 && last_hi >= 1, 1'b1);
`endif
        wait_done("b2b_b");
        repeat (2 * CLK_DIV + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
